tour_cmd_sched: RTL and testbench

Sequences a precomputed knight's tour into drive commands and shares the command processor between the UART path and the tour path. It sits between the UART command wrapper, the tour-solution move memory and `cmd_proc` inside `KnightsTour`. It decomposes each one-hot L-shaped knight move into a vertical leg followed by a horizontal leg. It then issues each leg through the same 16-bit command/ready handshake the UART uses.

---
 rtl/tour_pkg.sv | 32 +++
 rtl/tour_move_decode.sv | 29 ++
 rtl/tour_cmd_sched.sv | 156 +++++++++++++++
 tb/tb_tour_cmd_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared constants and FSM state type for the knight's tour command scheduler
package tour_pkg;

   // Command opcodes carried in cmd[15:12]
   localparam logic [3:0] OP_MOVE    = 4'h2;
   localparam logic [3:0] OP_FANFARE = 4'h3;

   // Headings carried in cmd[11:4]
   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   // Response bytes returned to the UART wrapper
   localparam logic [7:0] RESP_DONE = 8'hA5;
   localparam logic [7:0] RESP_POS  = 8'h5A;

   // Sequencer states: each move is a vertical leg then a horizontal leg
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VERT   = 3'd1,
      ST_WAIT_V = 3'd2,
      ST_HORZ   = 3'd3,
      ST_WAIT_H = 3'd4
   } tour_state_e;

   // Assemble a 16-bit drive command from an opcode and a {heading, squares} leg
   function automatic logic [15:0] make_cmd(input logic [3:0] op, input logic [11:0] leg);
      return {op, leg};
   endfunction

endpackage

// File: rtl/tour_move_decode.sv
// rtl/tour_move_decode.sv - splits a one-hot knight move into vertical and horizontal {heading, squares} legs
module tour_move_decode
   import tour_pkg::*;
(
   input  logic [7:0]  move,
   output logic [11:0] vert_leg,
   output logic [11:0] horz_leg,
   output logic        illegal
);

   // One-hot move table; anything that is not exactly one bit is flagged illegal
   always_comb begin
      vert_leg = {HDG_N, 4'd0};
      horz_leg = {HDG_E, 4'd0};
      illegal  = 1'b0;
      case (move)
         8'h01:   begin vert_leg = {HDG_N, 4'd2}; horz_leg = {HDG_E, 4'd1}; end // (+1,+2)
         8'h02:   begin vert_leg = {HDG_N, 4'd2}; horz_leg = {HDG_W, 4'd1}; end // (-1,+2)
         8'h04:   begin vert_leg = {HDG_N, 4'd1}; horz_leg = {HDG_W, 4'd2}; end // (-2,+1)
         8'h08:   begin vert_leg = {HDG_S, 4'd1}; horz_leg = {HDG_W, 4'd2}; end // (-2,-1)
         8'h10:   begin vert_leg = {HDG_S, 4'd2}; horz_leg = {HDG_W, 4'd1}; end // (-1,-2)
         8'h20:   begin vert_leg = {HDG_S, 4'd2}; horz_leg = {HDG_E, 4'd1}; end // (+1,-2)
         8'h40:   begin vert_leg = {HDG_S, 4'd1}; horz_leg = {HDG_E, 4'd2}; end // (+2,-1)
         8'h80:   begin vert_leg = {HDG_N, 4'd1}; horz_leg = {HDG_E, 4'd2}; end // (+2,+1)
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/tour_cmd_sched.sv
// rtl/tour_cmd_sched.sv - sequences tour moves into drive commands and muxes the UART path into cmd_proc (option: TOUR_FANFARE_EN)
module tour_cmd_sched #(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp,
   output logic        tour_busy,
   output logic        tour_err
);

   import tour_pkg::*;

   localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

`ifdef TOUR_FANFARE_EN
   localparam logic [3:0] OP_HORZ = OP_FANFARE;
`else
   localparam logic [3:0] OP_HORZ = OP_MOVE;
`endif

   tour_state_e state_q, state_d;
   logic [4:0]  mv_indx_q, mv_indx_d;
   logic [15:0] cmd_q, cmd_d;
   logic        cmd_rdy_q, cmd_rdy_d;
   logic        tour_err_q, tour_err_d;

   logic [11:0] vert_leg;
   logic [11:0] horz_leg;
   logic        illegal;

   tour_move_decode u_decode (
      .move     (move),
      .vert_leg (vert_leg),
      .horz_leg (horz_leg),
      .illegal  (illegal)
   );

   // State, index and registered tour command
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mv_indx_q  <= 5'd0;
         cmd_q      <= 16'h0000;
         cmd_rdy_q  <= 1'b0;
         tour_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mv_indx_q  <= mv_indx_d;
         cmd_q      <= cmd_d;
         cmd_rdy_q  <= cmd_rdy_d;
         tour_err_q <= tour_err_d;
      end
   end

   // Next-state logic; move memory is addressed by mv_indx_q, so a leg can only be
   // decoded once the index register already points at its move
   always_comb begin
      state_d    = state_q;
      mv_indx_d  = mv_indx_q;
      cmd_d      = cmd_q;
      cmd_rdy_d  = cmd_rdy_q;
      tour_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Index is always 0 in IDLE, so move[0] is on the bus right now
            if (start_tour) begin
               mv_indx_d = 5'd0;
               if (illegal) begin
                  tour_err_d = 1'b1;
               end else begin
                  state_d   = ST_VERT;
                  cmd_d     = make_cmd(OP_MOVE, vert_leg);
                  cmd_rdy_d = 1'b1;
               end
            end
         end
         ST_VERT: begin
            if (!cmd_rdy_q) begin
               // Arrived from WAIT_H with a fresh index: sample the new move now
               if (illegal) begin
                  tour_err_d = 1'b1;
                  state_d    = ST_IDLE;
                  mv_indx_d  = 5'd0;
               end else begin
                  cmd_d     = make_cmd(OP_MOVE, vert_leg);
                  cmd_rdy_d = 1'b1;
               end
            end else if (clr_cmd_rdy) begin
               cmd_rdy_d = 1'b0;
               state_d   = ST_WAIT_V;
            end
         end
         ST_WAIT_V: begin
            if (send_resp) begin
               state_d   = ST_HORZ;
               cmd_d     = make_cmd(OP_HORZ, horz_leg);
               cmd_rdy_d = 1'b1;
            end
         end
         ST_HORZ: begin
            if (clr_cmd_rdy) begin
               cmd_rdy_d = 1'b0;
               state_d   = ST_WAIT_H;
            end
         end
         ST_WAIT_H: begin
            if (send_resp) begin
               if (mv_indx_q == LAST_IDX) begin
                  state_d   = ST_IDLE;
                  mv_indx_d = 5'd0;
               end else begin
                  state_d   = ST_VERT;
                  mv_indx_d = mv_indx_q + 5'd1;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mv_indx_d = 5'd0;
            cmd_rdy_d = 1'b0;
         end
      endcase
   end

   // Output mux: UART owns cmd_proc in IDLE, the tour owns it otherwise
   always_comb begin
      cmd              = cmd_q;
      cmd_rdy          = cmd_rdy_q;
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_POS;
      if (state_q == ST_IDLE) begin
         cmd              = cmd_UART;
         cmd_rdy          = cmd_rdy_UART;
         clr_cmd_rdy_UART = clr_cmd_rdy;
         resp             = RESP_DONE;
      end else if (state_q == ST_WAIT_H && mv_indx_q == LAST_IDX) begin
         resp = RESP_DONE;
      end
   end

   assign mv_indx   = mv_indx_q;
   assign tour_busy = (state_q != ST_IDLE);
   assign tour_err  = tour_err_q;

endmodule

// File: tb/tb_tour_cmd_sched.sv
// tb/tb_tour_cmd_sched.sv - randomized self-checking bench for tour_cmd_sched
module tb_tour_cmd_sched;

   localparam int NM = 3;
   localparam int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
   localparam int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
`ifdef TOUR_FANFARE_EN
   localparam logic [3:0] EXP_OP_H = 4'h3;
`else
   localparam logic [3:0] EXP_OP_H = 4'h2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;
   logic        tour_busy;
   logic        tour_err;

   logic [7:0]  mem [0:31];
   int          vectors = 0;
   int          miscompares = 0;

   assign move = mem[mv_indx];

   tour_cmd_sched #(.NUM_MOVES(NM)) dut (
      .clk              (clk),
      .rst              (rst),
      .start_tour       (start_tour),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .cmd              (cmd),
      .cmd_rdy          (cmd_rdy),
      .clr_cmd_rdy      (clr_cmd_rdy),
      .send_resp        (send_resp),
      .resp             (resp),
      .tour_busy        (tour_busy),
      .tour_err         (tour_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int bit_of(input logic [7:0] m);
      int k;
      k = 0;
      for (int i = 0; i < 8; i++) if (m[i]) k = i;
      return k;
   endfunction

   // Reference: the vertical leg carries dy, the horizontal leg carries dx
   function automatic logic [15:0] exp_vert(input logic [7:0] m);
      int dy;
      dy = DY[bit_of(m)];
      return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
   endfunction

   function automatic logic [15:0] exp_horz(input logic [7:0] m);
      int dx;
      dx = DX[bit_of(m)];
      return {EXP_OP_H, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
   endfunction

   function automatic logic [7:0] rand_legal();
      return 8'h01 << $urandom_range(0, 7);
   endfunction

   function automatic logic [7:0] rand_illegal();
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      while ($countones(r) == 1) r = 8'($urandom_range(0, 255));
      return r;
   endfunction

   task automatic wait_rdy(input string name);
      int n;
      n = 0;
      while (cmd_rdy !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      vectors++;
      if (cmd_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s: cmd_rdy=%b after %0d cycles, required 1", name, cmd_rdy, n);
      end
   endtask

   task automatic start_pulse();
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      vectors++;
      if (cmd_rdy !== 1'b1 || tour_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL start_latency: cmd_rdy=%b tour_busy=%b, required 1 1", cmd_rdy, tour_busy);
      end
   endtask

   // Carry one move through both legs; stop_h leaves the DUT waiting for the horizontal response
   task automatic do_move(input int idx, input bit noise, input bit stop_h);
      logic [15:0] ev, eh;
      bit          last;
      ev   = exp_vert(mem[idx]);
      eh   = exp_horz(mem[idx]);
      last = (idx == NM - 1);
      wait_rdy("vert_rdy");
      vectors++;
      if (cmd !== ev || mv_indx !== 5'(idx)) begin
         miscompares++;
         $display("FAIL vert_cmd: cmd=%h idx=%0d, required %h idx=%0d", cmd, mv_indx, ev, idx);
      end
      // Response before consumption must be ignored
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      clr_cmd_rdy = 1'b1;
      #1;
      vectors++;
      if (clr_cmd_rdy_UART !== 1'b0 || cmd_rdy !== 1'b1 || cmd !== ev) begin
         miscompares++;
         $display("FAIL vert_hold: clr_uart=%b cmd_rdy=%b cmd=%h, required 0 1 %h", clr_cmd_rdy_UART, cmd_rdy, cmd, ev);
      end
      tick();
      clr_cmd_rdy = 1'b0;
      vectors++;
      if (cmd_rdy !== 1'b0 || cmd !== ev) begin
         miscompares++;
         $display("FAIL vert_clr: cmd_rdy=%b cmd=%h, required 0 %h", cmd_rdy, cmd, ev);
      end
      if (noise) begin
         start_tour = 1'b1;
         tick();
         start_tour = 1'b0;
      end
      vectors++;
      if (resp !== 8'h5A || tour_busy !== 1'b1 || cmd_rdy !== 1'b0 || mv_indx !== 5'(idx)) begin
         miscompares++;
         $display("FAIL wait_v: resp=%h busy=%b cmd_rdy=%b idx=%0d, required 5a 1 0 %0d", resp, tour_busy, cmd_rdy, mv_indx, idx);
      end
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      vectors++;
      if (cmd_rdy !== 1'b1 || cmd !== eh) begin
         miscompares++;
         $display("FAIL horz_cmd: cmd_rdy=%b cmd=%h, required 1 %h", cmd_rdy, cmd, eh);
      end
      clr_cmd_rdy = 1'b1;
      #1;
      vectors++;
      if (clr_cmd_rdy_UART !== 1'b0) begin
         miscompares++;
         $display("FAIL horz_clr_uart: clr_cmd_rdy_UART=%b, required 0", clr_cmd_rdy_UART);
      end
      tick();
      clr_cmd_rdy = 1'b0;
      vectors++;
      if (cmd_rdy !== 1'b0 || resp !== (last ? 8'hA5 : 8'h5A)) begin
         miscompares++;
         $display("FAIL wait_h: cmd_rdy=%b resp=%h, required 0 %h", cmd_rdy, resp, last ? 8'hA5 : 8'h5A);
      end
      if (!stop_h) begin
         if (last) cmd_rdy_UART = 1'b0;
         send_resp = 1'b1;
         tick();
         send_resp = 1'b0;
         vectors++;
         if (tour_busy !== !last || (last && (mv_indx !== 5'd0 || resp !== 8'hA5))) begin
            miscompares++;
            $display("FAIL move_end: busy=%b idx=%0d resp=%h, required busy %b", tour_busy, mv_indx, resp, !last);
         end
      end
   endtask

   task automatic run_tour(input bit noise);
      if (noise) begin
         cmd_UART     = 16'hFFFF;
         cmd_rdy_UART = 1'b1;
      end
      start_pulse();
      for (int i = 0; i < NM; i++) do_move(i, noise, 1'b0);
      cmd_rdy_UART = 1'b0;
      cmd_UART     = 16'h0000;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if (cmd_rdy !== 1'b0 || cmd !== 16'h0000 || tour_busy !== 1'b0 || tour_err !== 1'b0 ||
          resp !== 8'hA5 || mv_indx !== 5'd0) begin
         miscompares++;
         $display("FAIL reset: cmd_rdy=%b cmd=%h busy=%b err=%b resp=%h idx=%0d", cmd_rdy, cmd, tour_busy, tour_err, resp, mv_indx);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_passthrough();
      logic [15:0] v;
      for (int i = 0; i < 5; i++) begin
         v = (i == 0) ? 16'h2001 : 16'($urandom);
         cmd_UART     = v;
         cmd_rdy_UART = 1'b1;
         #1;
         vectors++;
         if (cmd !== v || cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_cmd: cmd=%h rdy=%b clr=%b, required %h 1 0", cmd, cmd_rdy, clr_cmd_rdy_UART, v);
         end
         clr_cmd_rdy = 1'b1;
         #1;
         vectors++;
         if (clr_cmd_rdy_UART !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_clr: clr_cmd_rdy_UART=%b, required 1", clr_cmd_rdy_UART);
         end
         tick();
         clr_cmd_rdy  = 1'b0;
         cmd_rdy_UART = 1'b0;
      end
      cmd_UART = 16'h0000;
      #1;
   endtask

   task automatic test_first_move();
      mem[0] = 8'h01;
      for (int i = 1; i < NM; i++) mem[i] = rand_legal();
      start_pulse();
      vectors++;
      if (cmd !== 16'h2002) begin
         miscompares++;
         $display("FAIL first_vert: cmd=%h, required 2002", cmd);
      end
      do_move(0, 1'b0, 1'b0);
      vectors++;
      if (mv_indx !== 5'd1) begin
         miscompares++;
         $display("FAIL first_idx: mv_indx=%0d, required 1", mv_indx);
      end
      for (int i = 1; i < NM; i++) do_move(i, 1'b0, 1'b0);
   endtask

   task automatic test_sequence();
      mem[0] = 8'h08;
      mem[1] = 8'h40;
      mem[2] = rand_legal();
      run_tour(1'b0);
   endtask

   task automatic test_uart_blocked();
      for (int i = 0; i < NM; i++) mem[i] = rand_legal();
      run_tour(1'b1);
   endtask

   task automatic test_random_tours();
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < NM; i++) mem[i] = rand_legal();
         run_tour(1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_illegal();
      int n;
      bit saw_rdy;
      // Illegal at index 0
      mem[0] = 8'h03;
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      vectors++;
      if (tour_err !== 1'b1 || cmd_rdy !== 1'b0 || tour_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal0: err=%b cmd_rdy=%b busy=%b, required 1 0 0", tour_err, cmd_rdy, tour_busy);
      end
      tick();
      vectors++;
      if (tour_err !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal0_pulse: tour_err=%b, required 0", tour_err);
      end
      // Illegal at a later index, after a legal move completes
      mem[0] = rand_legal();
      mem[1] = rand_illegal();
      start_pulse();
      do_move(0, 1'b0, 1'b0);
      n = 0;
      saw_rdy = 1'b0;
      while (tour_err !== 1'b1 && n < 6) begin
         if (cmd_rdy === 1'b1) saw_rdy = 1'b1;
         tick();
         n++;
      end
      vectors++;
      if (tour_err !== 1'b1 || saw_rdy || cmd_rdy !== 1'b0 || tour_busy !== 1'b0 || mv_indx !== 5'd0) begin
         miscompares++;
         $display("FAIL illegal1: err=%b saw_rdy=%b cmd_rdy=%b busy=%b idx=%0d move=%h", tour_err, saw_rdy, cmd_rdy, tour_busy, mv_indx, mem[1]);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < NM; i++) mem[i] = rand_legal();
      start_pulse();
      do_move(0, 1'b0, 1'b0);
      do_move(1, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      vectors++;
      if (tour_busy !== 1'b0 || mv_indx !== 5'd0 || cmd_rdy !== 1'b0 || resp !== 8'hA5) begin
         miscompares++;
         $display("FAIL reset_mid: busy=%b idx=%0d cmd_rdy=%b resp=%h, required 0 0 0 a5", tour_busy, mv_indx, cmd_rdy, resp);
      end
      tick();
      rst = 1'b0;
      tick();
      // The sequencer must be fully usable again after the abort
      for (int i = 0; i < NM; i++) mem[i] = rand_legal();
      run_tour(1'b0);
   endtask

   initial begin
      rst          = 1'b1;
      start_tour   = 1'b0;
      cmd_UART     = 16'h0000;
      cmd_rdy_UART = 1'b0;
      clr_cmd_rdy  = 1'b0;
      send_resp    = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 8'h01;
      test_reset();
      test_passthrough();
      test_first_move();
      test_sequence();
      test_uart_blocked();
      test_illegal();
      test_random_tours();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
